// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and width constants for the sequential
//                restoring divider and its combinational step cell.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    // Default operand widths (8-bit dividend/quotient, 4-bit divisor/remainder)
    localparam int DIVIDEND_W_DEF = 8;
    localparam int DIVISOR_W_DEF  = 4;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } div_state_e;

    // Step counter width; never narrower than one bit
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(DIVIDEND_W_DEF);

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One restoring-division step. Shifts the next dividend bit
//                into the partial remainder, compares against the divisor and
//                subtracts when it fits, yielding one quotient bit.
//  Revision    : 1.0 - initial release
// ============================================================================
import div_pkg::*;

module div_step #(
    parameter int DIVISOR_W = DIVISOR_W_DEF
) (
    input  logic [DIVISOR_W:0]   r_in,
    input  logic                 d_bit,
    input  logic [DIVISOR_W-1:0] v,
    output logic [DIVISOR_W:0]   r_out,
    output logic                 q_bit
);

    localparam int RW = DIVISOR_W + 1;
    localparam int SW = DIVISOR_W + 2;

    // Full-width shifted value so the compare never loses the top bit
    logic [SW-1:0] w_shift;

    // Trial subtraction; restore (keep shifted value) when divisor does not fit
    always_comb begin
        w_shift = {r_in, d_bit};
        r_out   = RW'(w_shift);
        q_bit   = 1'b0;
        if (w_shift >= SW'(v)) begin
            r_out = RW'(w_shift - SW'(v));
            q_bit = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_restoring_divider
//  Description : Sequential unsigned restoring divider, one quotient bit per
//                clock. Divide-by-zero completes in one cycle with an
//                all-ones quotient and a flag.
//  Revision    : 1.0 - initial release
// ============================================================================
import div_pkg::*;

module seq_restoring_divider #(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = cnt_width(DIVIDEND_W);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_FIN  = FIN;

    localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(DIVIDEND_W - 1);

    logic [1:0]            r_state;
    logic [DIVIDEND_W-1:0] r_d;       // dividend shifts out, quotient shifts in
    logic [DIVISOR_W-1:0]  r_v;
    logic [DIVISOR_W:0]    r_r;
    logic [CNT_W-1:0]      r_count;

    logic [DIVISOR_W:0]    w_r_next;
    logic                  w_q_bit;
    logic [DIVIDEND_W-1:0] w_d_next;

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .r_in  (r_r),
        .d_bit (r_d[DIVIDEND_W-1]),
        .v     (r_v),
        .r_out (w_r_next),
        .q_bit (w_q_bit)
    );

    // Dividend register after this step: shift left, new quotient bit at LSB
    assign w_d_next = {r_d[DIVIDEND_W-2:0], w_q_bit};

    // Controller and datapath registers; results update only at completion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_d         <= '0;
            r_v         <= '0;
            r_r         <= '0;
            r_count     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= '0;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            r_state     <= S_FIN;
                        end else begin
                            r_d     <= dividend;
                            r_v     <= divisor;
                            r_r     <= '0;
                            r_count <= C_CNT_INIT;
                            busy    <= 1'b1;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_d     <= w_d_next;
                    r_r     <= w_r_next;
                    r_count <= r_count - 1'b1;
                    if (r_count == '0) begin
                        quotient    <= w_d_next;
                        remainder   <= w_r_next[DIVISOR_W-1:0];
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        r_state     <= S_FIN;
                    end
                end
                S_FIN: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_restoring_divider
//  Description : Self-checking bench for seq_restoring_divider, comparing
//                against plain / and % arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_restoring_divider;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy, done, div_by_zero;
    logic [7:0] quotient;
    logic [3:0] remainder;

    int vectors = 0;
    int miscompares = 0;

    seq_restoring_divider dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference model: plain arithmetic, all-ones quotient on divide by zero
    function automatic logic [12:0] ref_div(input logic [7:0] a, input logic [3:0] b);
        if (b == 0) return {8'hFF, 4'h0, 1'b1};
        return {8'(a / b), 4'(a % b), 1'b0};
    endfunction

    // Drives one operation and observes it at falling edges. n_done counts
    // falling edges after the accepting edge up to the one that sees done
    // (0 = never seen); held_ok is cleared if results move before done.
    task automatic run_op(input logic [7:0] a, input logic [3:0] b, input bit poke,
                          output logic [12:0] res, output int n_done,
                          output int n_busy, output bit held_ok);
        logic [12:0] prev;
        @(negedge clk);
        prev = {quotient, remainder, div_by_zero};
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; dividend = 8'($urandom); divisor = 4'($urandom);
        n_done = 0; n_busy = 0; held_ok = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (poke && k == 3) begin
                start = 1'b1; dividend = 8'($urandom); divisor = 4'($urandom_range(15, 1));
            end
            if (poke && k == 5) start = 1'b0;
            if (busy) n_busy++;
            if (done) begin n_done = k; break; end
            if ({quotient, remainder, div_by_zero} !== prev) held_ok = 1'b0;
        end
        start = 1'b0;
        res = {quotient, remainder, div_by_zero};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %h want 0", {busy, done, quotient, remainder, div_by_zero});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [12:0] res; int nd, nb; bit h;
        run_op(8'd200, 4'd7, 1'b0, res, nd, nb, h);
        vectors++;
        if (res !== {8'd28, 4'd4, 1'b0}) begin
            miscompares++; $display("FAIL basic_result: got %h want %h", res, {8'd28, 4'd4, 1'b0});
        end
        vectors++;
        if (nd !== 9 || nb !== 8) begin
            miscompares++; $display("FAIL basic_timing: done@%0d busy=%0d want 9/8", nd, nb);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL basic_done_pulse: done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    task automatic test_extremes();
        logic [7:0] aa [5] = '{8'd255, 8'd5, 8'd0, 8'd255, 8'd15};
        logic [3:0] bb [5] = '{4'd1, 4'd15, 4'd9, 4'd15, 4'd15};
        logic [12:0] res; int nd, nb; bit h;
        for (int i = 0; i < 5; i++) begin
            run_op(aa[i], bb[i], 1'b0, res, nd, nb, h);
            vectors++;
            if (res !== ref_div(aa[i], bb[i]) || nd !== 9) begin
                miscompares++;
                $display("FAIL extreme %0d/%0d: got %h done@%0d want %h done@9", aa[i], bb[i], res, nd, ref_div(aa[i], bb[i]));
            end
        end
    endtask

    task automatic test_div_by_zero();
        logic [12:0] res; int nd, nb; bit h;
        run_op(8'd100, 4'd0, 1'b0, res, nd, nb, h);
        vectors++;
        if (res !== {8'hFF, 4'h0, 1'b1}) begin
            miscompares++; $display("FAIL dbz_result: got %h want %h", res, {8'hFF, 4'h0, 1'b1});
        end
        vectors++;
        if (nd !== 1 || nb !== 0) begin
            miscompares++; $display("FAIL dbz_timing: done@%0d busy=%0d want 1/0", nd, nb);
        end
        // flag clears on the next normal completion
        run_op(8'd9, 4'd3, 1'b0, res, nd, nb, h);
        vectors++;
        if (res !== {8'd3, 4'd0, 1'b0} || !h) begin
            miscompares++; $display("FAIL dbz_clear: got %h held=%b want %h held=1", res, h, {8'd3, 4'd0, 1'b0});
        end
    endtask

    task automatic test_start_ignored();
        logic [12:0] res; int nd, nb; bit h;
        run_op(8'd143, 4'd6, 1'b1, res, nd, nb, h);
        vectors++;
        if (res !== ref_div(8'd143, 4'd6) || nd !== 9) begin
            miscompares++; $display("FAIL start_in_run: got %h done@%0d want %h done@9", res, nd, ref_div(8'd143, 4'd6));
        end
    endtask

    task automatic test_reset_mid_op();
        int seen = 0;
        logic [12:0] res; int nd, nb; bit h;
        @(negedge clk);
        start = 1'b1; dividend = 8'd77; divisor = 4'd5;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        vectors++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_mid_op: got %h want 0", {busy, done, quotient, remainder, div_by_zero});
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++; $display("FAIL reset_abort: %0d cycles with busy/done want 0", seen);
        end
        run_op(8'd77, 4'd5, 1'b0, res, nd, nb, h);
        vectors++;
        if (res !== ref_div(8'd77, 4'd5) || nd !== 9) begin
            miscompares++; $display("FAIL after_reset: got %h done@%0d want %h", res, nd, ref_div(8'd77, 4'd5));
        end
    endtask

    task automatic test_random();
        logic [12:0] res; int nd, nb; bit h;
        logic [7:0] a; logic [3:0] b;
        for (int i = 0; i < 200; i++) begin
            a = 8'($urandom); b = 4'($urandom);
            run_op(a, b, 1'($urandom), res, nd, nb, h);
            vectors++;
            if (res !== ref_div(a, b) || nd !== ((b == 0) ? 1 : 9) || !h) begin
                miscompares++;
                $display("FAIL random %0d/%0d: got %h done@%0d held=%b want %h", a, b, res, nd, h, ref_div(a, b));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] res; int nd, nb; bit h;
        logic [7:0] a; logic [3:0] b;
        for (int i = 0; i < 4096; i++) begin
            a = 8'(i % 256); b = 4'(i / 256);
            run_op(a, b, 1'b0, res, nd, nb, h);
            vectors++;
            if (res !== ref_div(a, b) || nd !== ((b == 0) ? 1 : 9)
                || nb !== ((b == 0) ? 0 : 8) || !h) begin
                miscompares++;
                $display("FAIL exhaustive %0d/%0d: got %h done@%0d busy=%0d held=%b want %h", a, b, res, nd, nb, h, ref_div(a, b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_div_by_zero();
        test_start_ignored();
        test_reset_mid_op();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
